// File: rtl/shifter_serial_ctrl.sv
// shifter_serial_ctrl
//
// Sequencer sitting in front of an external parallel-load shifter. It takes a
// word on a valid/ready handshake and loads it into the shifter. It then
// clocks the word out serially while clocking ser_i in. After BUS_WIDTH shifts
// it presents the received word with a one-cycle rx_valid_o pulse.
//
// Ports
//   clk          system clock, rising edge
//   rst_i        asynchronous active-high reset
//   tx_data_i    word to transmit
//   tx_valid_i   tx_data_i valid
//   tx_ready_o   block can accept a word this cycle
//   ser_i        serial input bit
//   ser_o        serial output bit (shifter end bit, combinational)
//   shift_q_i    shifter register contents
//   load_data_o  shifter parallel-load word
//   select1_o    shifter mode code, bit 0
//   select2_o    shifter mode code, bit 1
//   dataR_o      shifter fill bit entering bit 0
//   dataL_o      shifter fill bit entering bit BUS_WIDTH-1
//   rx_data_o    received word
//   rx_valid_o   one-cycle pulse, rx_data_o valid
//   busy_o       transfer in progress
//
// Shifter mode code {select2_o, select1_o}:
//   00 hold | 01 parallel load | 10 shift toward MSB | 11 shift toward LSB
//
// state | meaning
// IDLE  | ready for a word; shifter held
// LOAD  | parallel-load the accepted word into the shifter
// SHIFT | one shift every BIT_CYCLES clocks, BUS_WIDTH shifts in total
// DONE  | capture shifter contents as the received word

module shifter_serial_ctrl #(
  parameter int BUS_WIDTH  = 8,
  parameter int BIT_CYCLES = 1,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_i,
  input  logic [BUS_WIDTH-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  input  logic                 ser_i,
  output logic                 ser_o,
  input  logic [BUS_WIDTH-1:0] shift_q_i,
  output logic [BUS_WIDTH-1:0] load_data_o,
  output logic                 select1_o,
  output logic                 select2_o,
  output logic                 dataR_o,
  output logic                 dataL_o,
  output logic [BUS_WIDTH-1:0] rx_data_o,
  output logic                 rx_valid_o,
  output logic                 busy_o
);

  localparam int BW = $clog2(BUS_WIDTH + 1);
  localparam int DW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  localparam logic [BW-1:0] BIT_LAST = BW'(BUS_WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(BIT_CYCLES - 1);

  localparam logic [1:0] CODE_HOLD  = 2'b00;
  localparam logic [1:0] CODE_LOAD  = 2'b01;
  localparam logic [1:0] CODE_SHIFT = MSB_FIRST ? 2'b10 : 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [BUS_WIDTH-1:0]   hold_q;
  logic [BW-1:0]          bit_cnt_q;
  logic [DW-1:0]          div_cnt_q;
  logic [BUS_WIDTH-1:0]   rx_data_q;
  logic                   rx_valid_q;
  logic [1:0]             code;
  logic                   accept;
  logic                   shift_en;

  // Ready is masked by reset so it stays low while rst_i is held and rises
  // in the first cycle after release.
  assign tx_ready_o = (state_q == IDLE) && !rst_i;

  always_comb begin
    state_d  = state_q;
    code     = CODE_HOLD;
    accept   = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_valid_i && tx_ready_o) begin
          accept  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        code    = CODE_LOAD;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          code     = CODE_SHIFT;
          shift_en = 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      bit_cnt_q  <= '0;
      div_cnt_q  <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_valid_q <= (state_q == DONE);
      if (accept) begin
        hold_q <= tx_data_i;
      end
      if (state_q == LOAD) begin
        bit_cnt_q <= '0;
        div_cnt_q <= '0;
      end else if (state_q == SHIFT) begin
        div_cnt_q <= (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DW'(1);
        if (shift_en) begin
          bit_cnt_q <= bit_cnt_q + BW'(1);
        end
      end
      if (state_q == DONE) begin
        rx_data_q <= shift_q_i;
      end
    end
  end

  assign {select2_o, select1_o} = code;
  assign load_data_o = hold_q;
  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign busy_o      = (state_q != IDLE);

  // The far end of the shifter in the shift direction is the outgoing bit.
  assign ser_o   = MSB_FIRST ? shift_q_i[BUS_WIDTH-1] : shift_q_i[0];
  assign dataR_o = MSB_FIRST ? ser_i : 1'b0;
  assign dataL_o = MSB_FIRST ? 1'b0  : ser_i;

endmodule

// File: tb/tb_shifter_serial_ctrl.sv
module tb_shifter_serial_ctrl;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  // Instance A: default parameters (BIT_CYCLES=1, MSB first)
  logic [7:0] a_tx_data, a_load, a_rx_data, a_q;
  logic       a_tx_valid, a_tx_ready, a_ser_i, a_ser_o, a_s1, a_s2;
  logic       a_dr, a_dl, a_rx_valid, a_busy, a_loop, a_fill;

  // Instance B: BIT_CYCLES=4, LSB first
  logic [7:0] b_tx_data, b_load, b_rx_data, b_q;
  logic       b_tx_valid, b_tx_ready, b_ser_i, b_ser_o, b_s1, b_s2;
  logic       b_dr, b_dl, b_rx_valid, b_busy, b_loop, b_fill;

  shifter_serial_ctrl u_a (
    .clk(clk), .rst_i(rst),
    .tx_data_i(a_tx_data), .tx_valid_i(a_tx_valid), .tx_ready_o(a_tx_ready),
    .ser_i(a_ser_i), .ser_o(a_ser_o), .shift_q_i(a_q), .load_data_o(a_load),
    .select1_o(a_s1), .select2_o(a_s2), .dataR_o(a_dr), .dataL_o(a_dl),
    .rx_data_o(a_rx_data), .rx_valid_o(a_rx_valid), .busy_o(a_busy)
  );

  shifter_serial_ctrl #(.BUS_WIDTH(8), .BIT_CYCLES(4), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst_i(rst),
    .tx_data_i(b_tx_data), .tx_valid_i(b_tx_valid), .tx_ready_o(b_tx_ready),
    .ser_i(b_ser_i), .ser_o(b_ser_o), .shift_q_i(b_q), .load_data_o(b_load),
    .select1_o(b_s1), .select2_o(b_s2), .dataR_o(b_dr), .dataL_o(b_dl),
    .rx_data_o(b_rx_data), .rx_valid_o(b_rx_valid), .busy_o(b_busy)
  );

  assign a_ser_i = a_loop ? a_ser_o : a_fill;
  assign b_ser_i = b_loop ? b_ser_o : b_fill;

  // Behavioural 8-bit shifters with parallel load; no reset, like the real part.
  initial a_q = 8'h00;
  initial b_q = 8'h00;

  always @(posedge clk) begin
    case ({a_s2, a_s1})
      2'b01:   a_q <= a_load;
      2'b10:   a_q <= {a_q[6:0], a_dr};
      2'b11:   a_q <= {a_dl, a_q[7:1]};
      default: a_q <= a_q;
    endcase
  end

  always @(posedge clk) begin
    case ({b_s2, b_s1})
      2'b01:   b_q <= b_load;
      2'b10:   b_q <= {b_q[6:0], b_dr};
      2'b11:   b_q <= {b_dl, b_q[7:1]};
      default: b_q <= b_q;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge with A idle; ends at the negedge inside the rx_valid cycle.
  task automatic run_a(input logic [7:0] w, input bit loop, input bit fill,
                       input logic [7:0] exp, input bit hold);
    a_loop = loop; a_fill = fill; a_tx_data = w; a_tx_valid = 1'b1;
    chk("a_ready_at_offer", {7'd0, a_tx_ready}, 8'd1);
    @(negedge clk);
    chk("a_code_load", {6'd0, a_s2, a_s1}, 8'd1);
    chk("a_load_data", a_load, w);
    chk("a_busy_load", {7'd0, a_busy}, 8'd1);
    if (hold) a_tx_data = 8'h11;
    else      a_tx_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("a_ser_o_bit", {7'd0, a_ser_o}, {7'd0, w[7-k]});
      chk("a_code_shift", {6'd0, a_s2, a_s1}, 8'd2);
    end
    @(negedge clk);
    chk("a_code_done", {6'd0, a_s2, a_s1}, 8'd0);
    chk("a_rx_valid_early", {7'd0, a_rx_valid}, 8'd0);
    chk("a_ready_done", {7'd0, a_tx_ready}, 8'd0);
    chk("a_load_kept", a_load, w);
    @(negedge clk);
    chk("a_rx_valid", {7'd0, a_rx_valid}, 8'd1);
    chk("a_rx_data", a_rx_data, exp);
    chk("a_ready_rx", {7'd0, a_tx_ready}, 8'd1);
    chk("a_busy_rx", {7'd0, a_busy}, 8'd0);
  endtask

  task automatic run_b(input logic [7:0] w, input bit loop, input logic [7:0] exp);
    b_loop = loop; b_fill = 1'b0; b_tx_data = w; b_tx_valid = 1'b1;
    chk("b_ready_at_offer", {7'd0, b_tx_ready}, 8'd1);
    @(negedge clk);
    chk("b_code_load", {6'd0, b_s2, b_s1}, 8'd1);
    b_tx_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk("b_ser_o_bit", {7'd0, b_ser_o}, {7'd0, w[k]});
        chk("b_code", {6'd0, b_s2, b_s1}, (c == 3) ? 8'd3 : 8'd0);
        chk("b_rx_valid_quiet", {7'd0, b_rx_valid}, 8'd0);
      end
    end
    @(negedge clk);
    chk("b_rx_valid_early", {7'd0, b_rx_valid}, 8'd0);
    @(negedge clk);
    chk("b_rx_valid", {7'd0, b_rx_valid}, 8'd1);
    chk("b_rx_data", b_rx_data, exp);
    chk("b_ready_rx", {7'd0, b_tx_ready}, 8'd1);
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    rst = 1'b1;
    a_tx_data = 8'h00; a_tx_valid = 1'b0; a_loop = 1'b0; a_fill = 1'b0;
    b_tx_data = 8'h00; b_tx_valid = 1'b0; b_loop = 1'b0; b_fill = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_a_ready", {7'd0, a_tx_ready}, 8'd0);
    chk("rst_a_busy", {7'd0, a_busy}, 8'd0);
    chk("rst_a_rx_valid", {7'd0, a_rx_valid}, 8'd0);
    chk("rst_a_rx_data", a_rx_data, 8'h00);
    chk("rst_a_load", a_load, 8'h00);
    chk("rst_a_code", {6'd0, a_s2, a_s1}, 8'd0);
    chk("rst_b_ready", {7'd0, b_tx_ready}, 8'd0);
    rst = 1'b0;
    #1;
    chk("rel_a_ready", {7'd0, a_tx_ready}, 8'd1);
    chk("rel_a_code", {6'd0, a_s2, a_s1}, 8'd0);
    chk("rel_b_ready", {7'd0, b_tx_ready}, 8'd1);
    @(negedge clk);

    // Loopback 0xA5
    run_a(8'hA5, 1'b1, 1'b0, 8'hA5, 1'b0);
    @(negedge clk);
    chk("a_rx_valid_pulse_end", {7'd0, a_rx_valid}, 8'd0);

    // Fill values
    run_a(8'h00, 1'b0, 1'b1, 8'hFF, 1'b0);
    @(negedge clk);
    run_a(8'hFF, 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);

    // BIT_CYCLES=4, LSB first, loopback 0x01
    run_b(8'h01, 1'b1, 8'h01);
    @(negedge clk);
    chk("b_rx_valid_pulse_end", {7'd0, b_rx_valid}, 8'd0);

    // Reset after 3 shifts of 0xF0
    a_loop = 1'b1; a_tx_data = 8'hF0; a_tx_valid = 1'b1;
    @(negedge clk);
    a_tx_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_code_before_rst", {6'd0, a_s2, a_s1}, 8'd2);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_code", {6'd0, a_s2, a_s1}, 8'd0);
    chk("mid_rst_ready", {7'd0, a_tx_ready}, 8'd0);
    chk("mid_rst_busy", {7'd0, a_busy}, 8'd0);
    chk("mid_rst_load", a_load, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_rx_valid", {7'd0, a_rx_valid}, 8'd0);
    end
    rst = 1'b0;
    #1;
    chk("mid_rel_ready", {7'd0, a_tx_ready}, 8'd1);
    @(negedge clk);
    run_a(8'h3C, 1'b1, 1'b0, 8'h3C, 1'b0);
    @(negedge clk);

    // Handshake: 0x11 held during 0x22, then accepted in the rx_valid cycle
    run_a(8'h22, 1'b1, 1'b0, 8'h22, 1'b1);
    run_a(8'h11, 1'b1, 1'b0, 8'h11, 1'b0);
    @(negedge clk);
    chk("a_final_rx_valid_low", {7'd0, a_rx_valid}, 8'd0);
    chk("a_final_busy", {7'd0, a_busy}, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/shifter_serial_ctrl.md
# shifter_serial_ctrl

Sequencer placed directly upstream of the 8-bit shifter with parallel load: drives its select lines, parallel-load word and serial fill bits, and reads its register output back. Accepts a parallel word on a valid/ready handshake, loads it into the shifter, then shifts it out serially while shifting a serial input in, SPI-style. After BUS_WIDTH shifts it presents the received word with a one-cycle valid pulse.

## Interface
- BUS_WIDTH, 8, word width; must match the shifter.
- BIT_CYCLES, 1, clocks per serial bit; must be ≥1.
- MSB_FIRST, 1, 1 = shift toward MSB (fill at bit 0), 0 = shift toward LSB (fill at MSB).

- clk  in  1  single clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- tx_data_i  in  BUS_WIDTH  word to transmit.
- tx_valid_i  in  1  tx_data_i is valid.
- tx_ready_o  out  1  block accepts a word this cycle.
- ser_i  in  1  serial input bit.
- ser_o  out  1  serial output bit.
- shift_q_i  in  BUS_WIDTH  shifter register output.
- load_data_o  out  BUS_WIDTH  to shifter parallel input.
- select1_o, select2_o  out  1 each  shifter mode code.
- dataR_o  out  1  shifter fill bit entering bit 0.
- dataL_o  out  1  shifter fill bit entering bit BUS_WIDTH-1.
- rx_data_o  out  BUS_WIDTH  received word.
- rx_valid_o  out  1  one-cycle pulse, rx_data_o valid.
- busy_o  out  1  transfer in progress.

## Operation
- Shifter mode code {select2_o, select1_o}: 00 hold, 01 parallel load, 10 shift toward MSB (dataR_o → bit 0), 11 shift toward LSB (dataL_o → MSB).
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: code 00; tx_ready_o=1. On tx_valid_i & tx_ready_o, register tx_data_i into hold register → LOAD. tx_valid_i in any other state is ignored.
- LOAD: code 01, load_data_o = hold register; clear div_cnt and bit_cnt → SHIFT.
- SHIFT: div_cnt counts 0..BIT_CYCLES-1, wrapping. Code 00 except when div_cnt==BIT_CYCLES-1: code 10 (MSB_FIRST=1) or 11 (MSB_FIRST=0) for that one cycle, and bit_cnt increments. On the BUS_WIDTH-th shift → DONE.
- DONE: code 00; capture shift_q_i into rx_data_o; set rx_valid_o for the next cycle → IDLE.
- ser_o = shift_q_i[BUS_WIDTH-1] if MSB_FIRST, else shift_q_i[0], combinational in all states.
- dataR_o = ser_i when MSB_FIRST, else 0. dataL_o = ser_i when MSB_FIRST=0, else 0. ser_i is combinational through and sampled by the shifter only on shift edges.
- busy_o = state ≠ IDLE. load_data_o holds the last accepted word outside LOAD.
- Counter widths: bit_cnt = clog2(BUS_WIDTH+1); div_cnt = max(1, clog2(BIT_CYCLES)).

## Timing
- Handshake edge E0: IDLE→LOAD.
- E0+1: shifter loaded, state SHIFT; ser_o shows the first bit.
- k-th shift occurs at edge E0+1+k·BIT_CYCLES, for k=1..BUS_WIDTH.
- rx_valid_o is high exactly in the cycle starting at E0+2+BUS_WIDTH·BIT_CYCLES; that cycle is IDLE with tx_ready_o=1.
- Back-to-back: a word offered in the rx_valid_o cycle is accepted. Throughput is one word per 3+BUS_WIDTH·BIT_CYCLES cycles.
- Each serial bit is stable on ser_o for BIT_CYCLES cycles.
- Reset while rst_i=1:
  - state IDLE; tx_ready_o=0; busy_o=0; rx_valid_o=0; rx_data_o=0.
  - hold register, load_data_o and all counters are 0.
  - select1_o=select2_o=0.
- tx_ready_o rises in the first cycle after rst_i deasserts.
- Reset mid-transfer:
  - mode code goes to 00 immediately (asynchronous); no rx_valid_o.
  - shifter contents are not cleared (shifter has no reset) and are don't-care until the next LOAD.

## Test plan
- Reset: assert rst_i mid-cycle → all outputs 0 at once, tx_ready_o=0. Release → tx_ready_o=1, mode code 00.
- Loopback (ser_i=ser_o), default parameters, send 0xA5:
  - ser_o sequence 1,0,1,0,0,1,0,1.
  - mode code 10 on 8 consecutive cycles.
  - rx_data_o=0xA5; rx_valid_o high one cycle, exactly 10 cycles after the handshake edge.
- Fill values, defaults:
  - ser_i held 1, send 0x00 → rx_data_o=0xFF.
  - ser_i held 0, send 0xFF → rx_data_o=0x00.
- BIT_CYCLES=4, MSB_FIRST=0, loopback, send 0x01:
  - ser_o sequence 1 then seven 0s, each held 4 cycles.
  - code 11 only on every 4th cycle.
  - rx_data_o=0x01; rx_valid_o 34 cycles after the handshake.
- Reset after 3 shifts of 0xF0:
  - mode code 00 immediately; no rx_valid_o.
  - after release, send 0x3C in loopback → rx_data_o=0x3C.
- Handshake rules:
  - tx_valid_i held with 0x11 during a transfer of 0x22 → only 0x22 received.
  - 0x11 offered in the rx_valid_o cycle → accepted with no idle gap.
